// File: rtl/logical_unit_iter.sv
// ---------------------------------------------------------------------------
// logical_unit_iter
//
// Iterative bitwise logic unit. A request (A, B, op) is captured in IDLE,
// then the result register is built CHUNK bits per cycle, lowest chunk
// first, over NCHUNK = WIDTH/CHUNK cycles. The finished result is offered
// with out_valid until the consumer takes it with out_ready.
//
// Parameters
//   WIDTH      operand / result width in bits (must be a multiple of CHUNK)
//   CHUNK      bits produced per BUSY cycle
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   request present on A, B, op
//   in_ready   unit can accept a request (IDLE only)
//   op         000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//              110 ANDN (A & ~B), 111 PASSA (A)
//   A, B       operands
//   out_valid  result and zero are valid (DONE only)
//   out_ready  consumer accepts the result
//   result     result register (holds its last value in IDLE)
//   zero       result == 0, meaningful while out_valid = 1
//   busy       high in BUSY or DONE
// ---------------------------------------------------------------------------
module logical_unit_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Counter is at least one bit wide so NCHUNK = 1 still elaborates.
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] op_res;

    // Full-width result of the latched operation; BUSY copies one chunk of
    // it per cycle into the result register. Purely bitwise, so each chunk
    // is independent of the others.
    always_comb begin
        // NOTE: default assignment first so no path leaves op_res unassigned,
        // which would otherwise infer a latch.
        op_res = '0;
        case (op_q)
            3'b000:  op_res = a_q & b_q;
            3'b001:  op_res = a_q | b_q;
            3'b010:  op_res = a_q ^ b_q;
            3'b011:  op_res = ~(a_q & b_q);
            3'b100:  op_res = ~(a_q | b_q);
            3'b101:  op_res = ~(a_q ^ b_q);
            3'b110:  op_res = a_q & ~b_q;
            default: op_res = a_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state  <= IDLE;
            cnt    <= '0;
            result <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= A;
                        b_q    <= B;
                        op_q   <= op;
                        result <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // Write only the chunk selected by cnt; the rest hold.
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (cnt == CW'(i)) begin
                            result[i*CHUNK +: CHUNK] <= op_res[i*CHUNK +: CHUNK];
                        end
                    end
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // in_valid is deliberately ignored here; a new request is
                    // only taken once back in IDLE.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign zero      = (result == '0);

endmodule
